instr_mem_dual: RTL and testbench

- Dual-read-port instruction memory that answers the core's two fetch ports. The core drives byte-addressed pc_A/pc_B; this block returns instr_A/instr_B one cycle later.
- Has a byte-serial loader used to program the memory before and between runs.
- Words not written by the current load read as all-zero. All-zero is the program-end marker the core uses to raise done.
- Sits between the testbench/loader and the core top, as the responder end of the fetch interface.

---
 rtl/instr_mem_dual.sv | 174 +++++++++++++++++
 tb/tb_instr_mem_dual.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_dual.sv
// Dual-read-port instruction memory with a byte-serial little-endian loader.
// Fetches are answered one cycle after sampling; unloaded words read as zero.
module instr_mem_dual #(
   parameter int                     ROM_ADDR_WIDTH = 8,
   parameter int                     INSTR_WIDTH    = 32,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = 32'h00000013
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_start,
   input  logic                      load_valid,
   input  logic [7:0]                load_byte,
   input  logic                      load_last,
   output logic                      load_ready,
   output logic                      loaded,
   input  logic                      fetch_en,
   input  logic [ROM_ADDR_WIDTH-1:0] pc_A,
   input  logic [ROM_ADDR_WIDTH-1:0] pc_B,
   output logic [INSTR_WIDTH-1:0]    instr_A,
   output logic [INSTR_WIDTH-1:0]    instr_B,
   output logic                      instr_valid,
   output logic                      end_A,
   output logic                      end_B,
   output logic                      misalign_A,
   output logic                      misalign_B
);

   localparam int IDX_W = ROM_ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             byte_cnt_q, byte_cnt_d;
   logic [IDX_W-1:0]       wptr_q, wptr_d;
   logic [IDX_W:0]         word_count_q, word_count_d;
   logic [INSTR_WIDTH-1:0] word_q, word_d;
   logic [INSTR_WIDTH-1:0] instr_a_q, instr_a_d, instr_b_q, instr_b_d;
   logic                   end_a_q, end_a_d, end_b_q, end_b_d;
   logic                   mis_a_q, mis_a_d, mis_b_q, mis_b_d;
   logic                   valid_q, valid_d;
   logic                   mem_we;
   logic [INSTR_WIDTH-1:0] mem_wdata;
   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]       idx_a, idx_b;

   assign idx_a = pc_A[ROM_ADDR_WIDTH-1:2];
   assign idx_b = pc_B[ROM_ADDR_WIDTH-1:2];

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      wptr_d       = wptr_q;
      word_count_d = word_count_q;
      word_d       = word_q;
      instr_a_d    = instr_a_q;
      instr_b_d    = instr_b_q;
      end_a_d      = end_a_q;
      end_b_d      = end_b_q;
      mis_a_d      = mis_a_q;
      mis_b_d      = mis_b_q;
      valid_d      = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      load_ready   = (state_q == LOAD);
      loaded       = (state_q == RUN);

      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d      = LOAD;
               byte_cnt_d   = '0;
               wptr_d       = '0;
               word_count_d = '0;
            end
         end
         LOAD: begin
            if (load_valid) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = load_byte;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3 || load_last) begin
                  // Lanes above the current byte may hold stale data from an earlier word.
                  mem_wdata = word_d;
                  for (int unsigned l = 0; l < 4; l++) begin
                     if (l > 32'(byte_cnt_q)) mem_wdata[8*l +: 8] = '0;
                  end
                  mem_we       = 1'b1;
                  byte_cnt_d   = '0;
                  wptr_d       = wptr_q + 1'b1;
                  word_count_d = word_count_q + 1'b1;
                  if (load_last || (&wptr_q)) state_d = RUN;
               end
            end
         end
         RUN: begin
            if (load_start) begin
               state_d      = LOAD;
               byte_cnt_d   = '0;
               wptr_d       = '0;
               word_count_d = '0;
            end else if (fetch_en) begin
               valid_d = 1'b1;
               mis_a_d = (pc_A[1:0] != 2'b00);
               mis_b_d = (pc_B[1:0] != 2'b00);
               if (mis_a_d) begin
                  instr_a_d = NOP_INSTR;
                  end_a_d   = 1'b0;
               end else if ({1'b0, idx_a} >= word_count_q) begin
                  instr_a_d = '0;
                  end_a_d   = 1'b1;
               end else begin
                  instr_a_d = mem_q[idx_a];
                  end_a_d   = (mem_q[idx_a] == '0);
               end
               if (mis_b_d) begin
                  instr_b_d = NOP_INSTR;
                  end_b_d   = 1'b0;
               end else if ({1'b0, idx_b} >= word_count_q) begin
                  instr_b_d = '0;
                  end_b_d   = 1'b1;
               end else begin
                  instr_b_d = mem_q[idx_b];
                  end_b_d   = (mem_q[idx_b] == '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         wptr_q       <= '0;
         word_count_q <= '0;
         word_q       <= '0;
         instr_a_q    <= NOP_INSTR;
         instr_b_q    <= NOP_INSTR;
         end_a_q      <= 1'b0;
         end_b_q      <= 1'b0;
         mis_a_q      <= 1'b0;
         mis_b_q      <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         wptr_q       <= wptr_d;
         word_count_q <= word_count_d;
         word_q       <= word_d;
         instr_a_q    <= instr_a_d;
         instr_b_q    <= instr_b_d;
         end_a_q      <= end_a_d;
         end_b_q      <= end_b_d;
         mis_a_q      <= mis_a_d;
         mis_b_q      <= mis_b_d;
         valid_q      <= valid_d;
      end
   end

   // Array is deliberately not reset; word_count gates every read instead.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n) mem_q[wptr_q] <= mem_wdata;
   end

   assign instr_A     = instr_a_q;
   assign instr_B     = instr_b_q;
   assign end_A       = end_a_q;
   assign end_B       = end_b_q;
   assign misalign_A  = mis_a_q;
   assign misalign_B  = mis_b_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_mem_dual.sv
// Self-checking bench for instr_mem_dual: directed loads and random fetches
// compared against a byte-array program model.
module tb_instr_mem_dual;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n, load_start, load_valid, load_last, fetch_en;
   logic [7:0]  load_byte, pc_A, pc_B;
   logic        load_ready, loaded, instr_valid, end_A, end_B, misalign_A, misalign_B;
   logic [31:0] instr_A, instr_B;

   int n_pass = 0, n_total = 0, n_fail = 0;

   logic [7:0]  prog [256];
   logic [31:0] model_mem [64];
   int          model_wc = 0;
   bit          model_loaded = 0;
   logic [31:0] exp_ia, exp_ib;
   logic        exp_ea, exp_eb, exp_ma, exp_mb;

   always #5 clk = ~clk;

   instr_mem_dual #(.ROM_ADDR_WIDTH(8), .INSTR_WIDTH(32), .NOP_INSTR(32'h00000013)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
      .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready), .loaded(loaded),
      .fetch_en(fetch_en), .pc_A(pc_A), .pc_B(pc_B), .instr_A(instr_A), .instr_B(instr_B),
      .instr_valid(instr_valid), .end_A(end_A), .end_B(end_B),
      .misalign_A(misalign_A), .misalign_B(misalign_B));

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic void model_slot(input logic [7:0] pc, output logic [31:0] ins,
                                      output logic e, output logic m);
      if (pc[1:0] != 2'b00) begin
         ins = NOP; e = 1'b0; m = 1'b1;
      end else if (int'(pc[7:2]) >= model_wc) begin
         ins = 32'h0; e = 1'b1; m = 1'b0;
      end else begin
         ins = model_mem[pc[7:2]]; e = (ins == 32'h0); m = 1'b0;
      end
   endfunction

   task automatic model_reset;
      model_wc = 0; model_loaded = 0;
      exp_ia = NOP; exp_ib = NOP;
      exp_ea = 0; exp_eb = 0; exp_ma = 0; exp_mb = 0;
   endtask

   task automatic check_outputs(input string tag, input logic exp_v);
      chk1({tag, "_valid"}, instr_valid, exp_v);
      chk32({tag, "_instrA"}, instr_A, exp_ia);
      chk32({tag, "_instrB"}, instr_B, exp_ib);
      chk1({tag, "_endA"}, end_A, exp_ea);
      chk1({tag, "_endB"}, end_B, exp_eb);
      chk1({tag, "_misA"}, misalign_A, exp_ma);
      chk1({tag, "_misB"}, misalign_B, exp_mb);
      chk1({tag, "_loaded"}, loaded, model_loaded);
   endtask

   task automatic do_reset;
      rst_n = 0; load_start = 0; load_valid = 0; load_last = 0; load_byte = 0;
      fetch_en = 0; pc_A = 0; pc_B = 0;
      step; step;
      rst_n = 1;
      model_reset();
   endtask

   task automatic fetch(input logic [7:0] pa, input logic [7:0] pb, input logic en);
      pc_A = pa; pc_B = pb; fetch_en = en;
      step;
      if (en && model_loaded) begin
         model_slot(pa, exp_ia, exp_ea, exp_ma);
         model_slot(pb, exp_ib, exp_eb, exp_mb);
      end
      check_outputs("fetch", en && model_loaded);
   endtask

   // Start cycle also presents a byte and a fetch; neither may take effect.
   task automatic do_load(input int n, input bit use_last);
      int i, cnt;
      load_start = 1; load_valid = 1; load_byte = 8'hEE; load_last = 0;
      fetch_en = 1'($urandom_range(0, 1)); pc_A = 0; pc_B = 4;
      step;
      load_start = 0; load_valid = 0; fetch_en = 0;
      model_loaded = 0;
      check_outputs("ldstart", 1'b0);
      chk1("ldstart_ready", load_ready, 1'b1);
      i = 0;
      while (i < n) begin
         if ($urandom_range(0, 3) == 0) begin
            load_valid = 0;
            step;
         end else begin
            load_valid = 1; load_byte = prog[i];
            load_last = use_last && (i == n - 1);
            step;
            i++;
         end
      end
      load_valid = 0; load_last = 0;
      cnt = (n + 3) / 4;
      if (cnt > 64) cnt = 64;
      for (int w = 0; w < cnt; w++) model_mem[w] = 32'h0;
      for (int b = 0; b < n && b < 256; b++)
         model_mem[b / 4] = model_mem[b / 4] | (32'(prog[b]) << (8 * (b % 4)));
      model_wc = cnt; model_loaded = 1;
      chk1("ldend_loaded", loaded, 1'b1);
      chk1("ldend_ready", load_ready, 1'b0);
   endtask

   initial begin
      do_reset();
      check_outputs("reset", 1'b0);
      chk1("reset_ready", load_ready, 1'b0);
      fetch(8'd0, 8'd4, 1'b1);

      // 8-word program
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      do_load(32, 1);
      fetch(8'd0, 8'd4, 1'b1);

      // short program with zero-filled tail
      prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC;
      prog[3] = 8'hDD; prog[4] = 8'h11; prog[5] = 8'h22;
      do_load(6, 1);
      fetch(8'd0, 8'd4, 1'b1);
      chk32("short_w0", instr_A, 32'hDDCCBBAA);
      chk32("short_w1", instr_B, 32'h00002211);
      fetch(8'd8, 8'd0, 1'b1);
      chk1("short_endA", end_A, 1'b1);
      fetch(8'd2, 8'd8, 1'b1);
      chk32("mis_nop", instr_A, 32'h00000013);

      // full-depth program, auto-complete without load_last
      for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
      for (int i = 20; i < 24; i++) prog[i] = 8'h00;
      do_load(256, 0);
      load_valid = 1; load_byte = 8'h5A;
      step;
      load_valid = 0;
      chk1("full_ready_after", load_ready, 1'b0);
      fetch(8'd252, 8'd20, 1'b1);
      fetch(8'd0, 8'd248, 1'b1);

      // streaming with fetch_en toggling
      for (int k = 0; k < 24; k++)
         fetch(8'(8 * k), 8'($urandom) & 8'hFC, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 20; k++)
         fetch(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));

      // reset mid-load discards partial program
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      load_start = 1;
      step;
      load_start = 0;
      for (int i = 0; i < 10; i++) begin
         load_valid = 1; load_byte = 8'($urandom);
         step;
      end
      load_valid = 0;
      rst_n = 0;
      step;
      rst_n = 1;
      model_reset();
      check_outputs("midrst", 1'b0);
      chk1("midrst_ready", load_ready, 1'b0);
      fetch(8'd0, 8'd16, 1'b1);
      do_load(16, 1);
      fetch(8'd16, 8'd12, 1'b1);
      chk1("midrst_endA", end_A, 1'b1);
      chk32("midrst_instrA", instr_A, 32'h0);

      // random-length program and random fetches
      begin
         int n;
         n = $urandom_range(1, 120);
         for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
         do_load(n, 1);
      end
      for (int k = 0; k < 30; k++)
         fetch(8'($urandom) & 8'h7F, 8'($urandom) & 8'h7F, 1'($urandom_range(0, 3) != 0));
      fetch(8'd40, 8'd40, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
